// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader for instruction RAM with checksum-gated core release
// Frame: MAGIC, LEN_H, LEN_L, 4*LEN little-endian data bytes, CSUM (mod-256 sum of data bytes).
module prog_loader #(
  parameter logic [7:0] MAGIC  = 8'hA5,
  parameter int         ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN_H = 3'd1,
    ST_LEN_L = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [15:0]         r_len;
  logic [7:0]          r_sum;
  logic [ADDR_W-1:0]   r_idx;
  logic [1:0]          r_bcnt;
  logic [23:0]         r_asm;
  logic                r_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_hold;
  logic                r_done;
  logic                r_err;

  logic                w_fire;
  logic                w_last_word;

  assign w_fire      = i_in_valid & r_ready;
  assign w_last_word = (16'(r_idx) == (r_len - 16'd1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_fire && (i_in_data == MAGIC)) w_state_nxt = ST_LEN_H;
      ST_LEN_H: if (w_fire) w_state_nxt = ST_LEN_L;
      ST_LEN_L: if (w_fire) w_state_nxt = ({r_len[15:8], i_in_data} == 16'd0) ? ST_CSUM : ST_DATA;
      ST_DATA:  if (w_fire && (r_bcnt == 2'd3) && w_last_word) w_state_nxt = ST_CSUM;
      ST_CSUM:  if (w_fire) w_state_nxt = (i_in_data == r_sum) ? ST_DONE : ST_ERR;
      ST_DONE,
      ST_ERR:   if (i_start) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change with the state itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_bcnt  <= '0;
      r_asm   <= '0;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != ST_DONE) && (w_state_nxt != ST_ERR);
      r_done  <= (w_state_nxt == ST_DONE);
      r_err   <= (w_state_nxt == ST_ERR);
      r_hold  <= (w_state_nxt != ST_DONE);
      r_we    <= 1'b0;
      if (w_fire) begin
        case (r_state)
          ST_LEN_H: r_len[15:8] <= i_in_data;
          ST_LEN_L: begin
            r_len[7:0] <= i_in_data;
            r_sum      <= '0;
            r_idx      <= '0;
            r_bcnt     <= '0;
          end
          ST_DATA: begin
            r_sum  <= r_sum + i_in_data;
            r_bcnt <= r_bcnt + 2'd1;
            r_asm  <= {i_in_data, r_asm[23:8]};
            if (r_bcnt == 2'd3) begin
              r_wdata <= {i_in_data, r_asm};
              r_addr  <= r_idx;
              r_idx   <= r_idx + 1'b1;
              r_we    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_in_ready  = r_ready;
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_cpu_hold  = r_hold;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;
  localparam int ADDR_W = 16;
  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  prog_loader #(.MAGIC(8'hA5), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_cpu_hold(cpu_hold), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int         wr_cyc[$];
  int         acc_cyc[$];
  logic       pre_done;
  logic       pre_err;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(32'(mem_addr));
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int  tries;
    logic rdy;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    tries    = 0;
    forever begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      tries++;
      if (tries > 20) begin
        check_eq("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    acc_cyc.push_back(cyc);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input int maxgap);
    foreach (f[i]) begin
      if (i == f.size() - 1) begin
        pre_done = done;
        pre_err  = err;
      end
      send(f[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_wr(input string tag, input int k, input logic [31:0] a, input logic [31:0] d);
    if (k < wr_addr.size()) begin
      check_eq({tag, "_addr"}, wr_addr[k], a);
      check_eq({tag, "_data"}, wr_data[k], d);
    end else begin
      check_eq({tag, "_missing"}, 32'd0, 32'd1);
    end
  endtask

  bq_t f1;
  bq_t f2;
  bq_t f3;
  bq_t f4;
  bq_t f5;
  bq_t fpart;

  initial begin
    // Data sum 0x78+0x56+0x34+0x12+0xEF+0xBE+0xAD+0xDE = 0x44C -> checksum 0x4C
    f1    = '{8'hA5, 8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    f2    = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    f3    = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
    f4    = '{8'hA5, 8'h00, 8'h00, 8'h00};
    f5    = '{8'hA5, 8'h00, 8'h00, 8'h01};
    fpart = '{8'hA5, 8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF};

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    clear_log();
    send_frame(f1, 0);
    check_eq("s1_done_pre", 32'(pre_done), 32'd0);
    check_eq("s1_done", 32'(done), 32'd1);
    check_eq("s1_hold", 32'(cpu_hold), 32'd0);
    check_eq("s1_ready", 32'(in_ready), 32'd0);
    check_eq("s1_nwr", 32'(wr_addr.size()), 32'd2);
    check_wr("s1_w0", 0, 32'd0, 32'h12345678);
    check_wr("s1_w1", 1, 32'd1, 32'hDEADBEEF);
    if (wr_cyc.size() >= 2) begin
      check_eq("s1_w0_lat", 32'(wr_cyc[0]), 32'(acc_cyc[6]));
      check_eq("s1_w1_lat", 32'(wr_cyc[1]), 32'(acc_cyc[10]));
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq("s1_done_hold", 32'(done), 32'd1);
    pulse_start();
    check_eq("s1_restart_done", 32'(done), 32'd0);
    check_eq("s1_restart_hold", 32'(cpu_hold), 32'd1);

    clear_log();
    send_frame(f2, 0);
    check_eq("s2_nwr", 32'(wr_addr.size()), 32'd1);
    check_wr("s2_w0", 0, 32'd0, 32'h00000001);
    check_eq("s2_done", 32'(done), 32'd1);
    pulse_start();

    clear_log();
    send_frame(f3, 0);
    check_eq("s3_nwr", 32'(wr_addr.size()), 32'd1);
    check_wr("s3_w0", 0, 32'd0, 32'h04030201);
    check_eq("s3_err_pre", 32'(pre_err), 32'd0);
    check_eq("s3_err", 32'(err), 32'd1);
    check_eq("s3_done", 32'(done), 32'd0);
    check_eq("s3_hold", 32'(cpu_hold), 32'd1);
    check_eq("s3_ready", 32'(in_ready), 32'd0);
    pulse_start();
    check_eq("s3_start_err", 32'(err), 32'd0);
    check_eq("s3_start_ready", 32'(in_ready), 32'd1);

    clear_log();
    send_frame(f4, 0);
    check_eq("s4_nwr", 32'(wr_addr.size()), 32'd0);
    check_eq("s4_done", 32'(done), 32'd1);
    pulse_start();
    send_frame(f5, 0);
    check_eq("s4_bad_err", 32'(err), 32'd1);
    check_eq("s4_bad_done", 32'(done), 32'd0);
    pulse_start();

    clear_log();
    send_frame(f1, 3);
    check_eq("s5_nwr", 32'(wr_addr.size()), 32'd2);
    check_wr("s5_w0", 0, 32'd0, 32'h12345678);
    check_wr("s5_w1", 1, 32'd1, 32'hDEADBEEF);
    if (wr_cyc.size() >= 2) begin
      check_eq("s5_w0_lat", 32'(wr_cyc[0]), 32'(acc_cyc[6]));
      check_eq("s5_w1_lat", 32'(wr_cyc[1]), 32'(acc_cyc[10]));
    end
    check_eq("s5_done_pre", 32'(pre_done), 32'd0);
    check_eq("s5_done", 32'(done), 32'd1);
    pulse_start();

    send_frame(fpart, 1);
    rst_n = 1'b0;
    #1;
    check_eq("s6_rst_hold", 32'(cpu_hold), 32'd1);
    check_eq("s6_rst_we", 32'(mem_we), 32'd0);
    check_eq("s6_rst_ready", 32'(in_ready), 32'd1);
    check_eq("s6_rst_addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    send_frame(f1, 0);
    check_eq("s6_nwr", 32'(wr_addr.size()), 32'd2);
    check_wr("s6_w0", 0, 32'd0, 32'h12345678);
    check_wr("s6_w1", 1, 32'd1, 32'hDEADBEEF);
    check_eq("s6_done", 32'(done), 32'd1);
    check_eq("s6_hold", 32'(cpu_hold), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
